// File: rtl/text_line.sv
// text_line: one line of N_CHARS character cells drawn at a fixed screen
// position. The render path turns the current pixel coordinate into a font
// ROM address and glyph column one clock later. A small FSM can fill the line
// with spaces, one cell per cycle. An optional frame-based blink blanks the
// whole line on alternate half-periods.
module text_line #(
    parameter int N_CHARS      = 8,
    parameter int START_X      = 364,
    parameter int START_Y      = 400,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        frame_start,
    input  logic        wr_en,
    input  logic [5:0]  wr_idx,
    input  logic [6:0]  wr_char,
    output logic        wr_ready,
    input  logic        clr_req,
    output logic        busy,
    input  logic        blink_en,
    output logic        is_text,
    output logic [10:0] sprite_addr,
    output logic [2:0]  bit_idx
);

    localparam logic [6:0]  SPACE      = 7'h20;
    // Bounds are widened to 12 bits so the hit test never wraps at 0 or 1023.
    localparam logic [11:0] X_LO       = 12'(START_X);
    localparam logic [11:0] X_HI       = 12'(START_X + 8 * N_CHARS);
    localparam logic [11:0] Y_LO       = 12'(START_Y);
    localparam logic [11:0] Y_HI       = 12'(START_Y + 16);
    localparam logic [5:0]  LAST_IDX   = 6'(N_CHARS - 1);
    localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t      state_reg;
    logic [5:0]  clr_idx_reg;
    logic        busy_reg;
    logic [7:0]  blink_cnt_reg;
    logic        phase_reg;
    logic        is_text_reg;
    logic [10:0] sprite_addr_reg;
    logic [2:0]  bit_idx_reg;

    logic [6:0]  cell_val [N_CHARS];
    logic        wr_accept;

    logic [11:0] dx;
    logic [11:0] dy;
    logic [11:0] dx_off;
    logic [3:0]  row;
    logic        hit;
    logic        blanked;
    logic [6:0]  char_sel;

    assign wr_ready  = !busy_reg && !Reset;
    assign wr_accept = wr_en && wr_ready;
    assign busy      = busy_reg;

    // Clear FSM: IDLE waits for clr_req, CLEAR walks every cell once.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg   <= IDLE;
            clr_idx_reg <= '0;
            busy_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (clr_req) begin
                        state_reg   <= CLEAR;
                        clr_idx_reg <= '0;
                        busy_reg    <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_idx_reg == LAST_IDX) begin
                        state_reg   <= IDLE;
                        clr_idx_reg <= '0;
                        busy_reg    <= 1'b0;
                    end else begin
                        clr_idx_reg <= clr_idx_reg + 6'd1;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    clr_idx_reg <= '0;
                    busy_reg    <= 1'b0;
                end
            endcase
        end
    end

    // One register per cell; out-of-range write indices match no cell and
    // are therefore dropped without any extra logic.
    generate
        for (genvar gi = 0; gi < N_CHARS; gi++) begin : g_cell
            logic [6:0] cell_reg;

            // Cell update: reset and clear load a space, otherwise take the write.
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    cell_reg <= SPACE;
                end else if (state_reg == CLEAR && clr_idx_reg == 6'(gi)) begin
                    cell_reg <= SPACE;
                end else if (wr_accept && wr_idx == 6'(gi)) begin
                    cell_reg <= wr_char;
                end
            end

            assign cell_val[gi] = cell_reg;
        end
    endgenerate

    // Blink timing: count frames, flip the phase every BLINK_FRAMES frames.
    always_ff @(posedge Clk) begin
        if (Reset || !blink_en) begin
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
        end else if (frame_start) begin
            if (blink_cnt_reg == BLINK_LAST) begin
                blink_cnt_reg <= '0;
                phase_reg     <= !phase_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + 8'd1;
            end
        end
    end

    assign dx      = {2'b00, DrawX};
    assign dy      = {2'b00, DrawY};
    assign dx_off  = dx - X_LO;
    assign row     = 4'(dy - Y_LO);
    assign hit     = (dx >= X_LO) && (dx < X_HI) && (dy >= Y_LO) && (dy < Y_HI);
    assign blanked = blink_en && phase_reg;

    // Select the character of the cell under the pixel.
    always_comb begin
        char_sel = '0;
        for (int i = 0; i < N_CHARS; i++) begin
            if (dx_off[11:3] == 9'(i)) begin
                char_sel = cell_val[i];
            end
        end
    end

    // Registered render outputs, forced to zero on miss, blank or reset.
    always_ff @(posedge Clk) begin
        if (Reset || !hit || blanked) begin
            is_text_reg     <= 1'b0;
            sprite_addr_reg <= '0;
            bit_idx_reg     <= '0;
        end else begin
            is_text_reg     <= 1'b1;
            sprite_addr_reg <= {char_sel, row};
            bit_idx_reg     <= dx_off[2:0];
        end
    end

    assign is_text     = is_text_reg;
    assign sprite_addr = sprite_addr_reg;
    assign bit_idx     = bit_idx_reg;

endmodule
